interrupt_priority_arbiter: RTL and testbench

Clocked request-side arbiter of the 8259 PIC. Holds the Interrupt Request Register (IRR) and In-Service Register (ISR) and resolves the highest-priority unmasked request under the programmable rotation. It drives the CPU interrupt line and sequences the INTA pulse handshake, which is 2 pulses in 8086 mode and 3 in MCS-80 mode. It consumes the mask, EOI, rotation and mode outputs of `control_logic`, and returns `highest_level_in_service`, `acknowledge_interrupt` and the end-of-acknowledge pulse to it.

---
 rtl/interrupt_priority_arbiter_if.sv | 39 +++
 rtl/interrupt_priority_arbiter.sv | 100 ++++++++++
 tb/tb_interrupt_priority_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_priority_arbiter_if.sv
// interrupt_priority_arbiter_if: request, control and INTA signals shared by the 8259 arbiter and its environment.
// master drives requests and controls; slave is the arbiter.
interface interrupt_priority_arbiter_if;
    logic [7:0] interrupt_request;
    logic       level_or_edge_triggered;
    logic       special_fully_nested_mode;
    logic [7:0] interrupt_mask;
    logic [7:0] special_interrupt_mask;
    logic [2:0] priority_rotate;
    logic [7:0] end_of_interrupt;
    logic       clear_all;
    logic       interrupt_acknowledge;
    logic       u8086_or_mcs80_config;
    logic       interrupt_to_cpu;
    logic [7:0] interrupt_request_register;
    logic [7:0] in_service_register;
    logic [7:0] highest_level_in_service;
    logic [7:0] acknowledge_interrupt;
    logic [1:0] vector_byte_select;
    logic       end_of_acknowledge_sequence;

    modport master (
        output interrupt_request, level_or_edge_triggered, special_fully_nested_mode,
               interrupt_mask, special_interrupt_mask, priority_rotate, end_of_interrupt,
               clear_all, interrupt_acknowledge, u8086_or_mcs80_config,
        input  interrupt_to_cpu, interrupt_request_register, in_service_register,
               highest_level_in_service, acknowledge_interrupt, vector_byte_select,
               end_of_acknowledge_sequence
    );

    modport slave (
        input  interrupt_request, level_or_edge_triggered, special_fully_nested_mode,
               interrupt_mask, special_interrupt_mask, priority_rotate, end_of_interrupt,
               clear_all, interrupt_acknowledge, u8086_or_mcs80_config,
        output interrupt_to_cpu, interrupt_request_register, in_service_register,
               highest_level_in_service, acknowledge_interrupt, vector_byte_select,
               end_of_acknowledge_sequence
    );
endinterface

// File: rtl/interrupt_priority_arbiter.sv
// interrupt_priority_arbiter: 8259 IRR/ISR holding, rotating-priority resolution and INTA sequencing.
// Raises INT to the CPU and walks the 2- (8086) or 3-pulse (MCS-80) acknowledge handshake.
module interrupt_priority_arbiter #(
    parameter int NUM_IRQ = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    interrupt_priority_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACK1 = 2'd1, ACK2 = 2'd2} state_t;

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   irr_q, irr_d;
    logic [NUM_IRQ-1:0]   isr_q, isr_d;
    logic [NUM_IRQ-1:0]   ack_int_q, ack_int_d;
    logic [NUM_IRQ-1:0]   prev_req_q, prev_req_d;
    logic                 prev_ack_q;
    logic                 int_q, int_d;
    logic                 eoa_q, eoa_d;
    logic                 ack_rise, first_ack, wins;
    logic [NUM_IRQ-1:0]   candidate, hlis, set;
    logic [2:0]           lvl_c, lvl_h;

    // Highest-priority set bit, where IR(r+1) outranks IR(r+2) ... and IR(r) is lowest.
    function automatic logic [7:0] pick(input logic [7:0] v, input logic [2:0] r);
        logic [7:0] res;
        logic [2:0] idx;
        res = '0;
        for (int i = 7; i >= 0; i--) begin
            idx = r + 3'(i) + 3'd1;
            if (v[idx]) res = 8'b1 << idx;
        end
        return res;
    endfunction

    // Priority rank of a one-hot vector: 0 is highest.
    function automatic logic [2:0] rank(input logic [7:0] oh, input logic [2:0] r);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) idx = 3'(i);
        return idx - r - 3'd1;
    endfunction

    always_comb begin
        ack_rise   = bus.interrupt_acknowledge & ~prev_ack_q;
        first_ack  = (state_q == IDLE) && ack_rise;
        candidate  = pick(irr_q & ~bus.interrupt_mask, bus.priority_rotate);
        hlis       = pick(isr_q & ~bus.special_interrupt_mask, bus.priority_rotate);
        lvl_c      = rank(candidate, bus.priority_rotate);
        lvl_h      = rank(hlis, bus.priority_rotate);
        set        = first_ack ? candidate : '0;
        wins       = (candidate != '0) && ((hlis == '0) || (lvl_c < lvl_h) ||
                     (bus.special_fully_nested_mode && (lvl_c == lvl_h)));
        state_d    = bus.clear_all ? IDLE :
                     !ack_rise ? state_q :
                     (state_q == IDLE) ? ACK1 :
                     ((state_q == ACK1) && !bus.u8086_or_mcs80_config) ? ACK2 : IDLE;
        irr_d      = bus.clear_all ? '0 :
                     bus.level_or_edge_triggered ? (bus.interrupt_request & ~set) :
                     (irr_q | (bus.interrupt_request & ~prev_req_q)) & bus.interrupt_request & ~set;
        // A bit being set this cycle survives a simultaneous EOI for it.
        isr_d      = bus.clear_all ? '0 : (isr_q | set) & ~(bus.end_of_interrupt & ~set);
        int_d      = !bus.clear_all && (state_q == IDLE) && !ack_rise && wins;
        ack_int_d  = bus.clear_all ? '0 :
                     first_ack ? ((candidate == '0) ? 8'h80 : candidate) : ack_int_q;
        eoa_d      = !bus.clear_all && (state_q != IDLE) && (state_d == IDLE);
        prev_req_d = bus.clear_all ? '1 : bus.interrupt_request;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            irr_q      <= '0;
            isr_q      <= '0;
            ack_int_q  <= '0;
            prev_req_q <= '1;
            prev_ack_q <= 1'b0;
            int_q      <= 1'b0;
            eoa_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            irr_q      <= irr_d;
            isr_q      <= isr_d;
            ack_int_q  <= ack_int_d;
            prev_req_q <= prev_req_d;
            prev_ack_q <= bus.interrupt_acknowledge;
            int_q      <= int_d;
            eoa_q      <= eoa_d;
        end
    end

    assign bus.interrupt_to_cpu            = int_q;
    assign bus.interrupt_request_register  = irr_q;
    assign bus.in_service_register         = isr_q;
    assign bus.highest_level_in_service    = hlis;
    assign bus.acknowledge_interrupt       = ack_int_q;
    assign bus.vector_byte_select          = state_q;
    assign bus.end_of_acknowledge_sequence = eoa_q;
endmodule

// File: tb/tb_interrupt_priority_arbiter.sv
// tb_interrupt_priority_arbiter: directed vectors with hand-computed expectations for the 8259 arbiter.
module tb_interrupt_priority_arbiter;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;

    interrupt_priority_arbiter_if bus();

    interrupt_priority_arbiter #(.NUM_IRQ(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic inta();
        bus.interrupt_acknowledge = 1'b1;
        step();
        bus.interrupt_acknowledge = 1'b0;
    endtask

    task automatic eoi(input logic [7:0] v);
        bus.end_of_interrupt = v;
        step();
        bus.end_of_interrupt = 8'h00;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_int"},  {7'd0, bus.interrupt_to_cpu}, 8'h00);
        chk({tag, "_irr"},  bus.interrupt_request_register, 8'h00);
        chk({tag, "_isr"},  bus.in_service_register, 8'h00);
        chk({tag, "_hlis"}, bus.highest_level_in_service, 8'h00);
        chk({tag, "_ack"},  bus.acknowledge_interrupt, 8'h00);
        chk({tag, "_sel"},  {6'd0, bus.vector_byte_select}, 8'h00);
        chk({tag, "_eoa"},  {7'd0, bus.end_of_acknowledge_sequence}, 8'h00);
    endtask

    initial begin
        bus.interrupt_request         = 8'h00;
        bus.level_or_edge_triggered   = 1'b0;
        bus.special_fully_nested_mode = 1'b0;
        bus.interrupt_mask            = 8'h00;
        bus.special_interrupt_mask    = 8'h00;
        bus.priority_rotate           = 3'd7;
        bus.end_of_interrupt          = 8'h00;
        bus.clear_all                 = 1'b0;
        bus.interrupt_acknowledge     = 1'b0;
        bus.u8086_or_mcs80_config     = 1'b1;
        step();
        step();
        all_zero("rst");
        reset = 1'b0;
        step();

        // IR3 through a full 8086 acknowledge
        bus.interrupt_request = 8'h08;
        step();
        chk("ir3_irr", bus.interrupt_request_register, 8'h08);
        chk("ir3_int0", {7'd0, bus.interrupt_to_cpu}, 8'h00);
        step();
        chk("ir3_int1", {7'd0, bus.interrupt_to_cpu}, 8'h01);
        inta();
        chk("ack1_isr", bus.in_service_register, 8'h08);
        chk("ack1_irr", bus.interrupt_request_register, 8'h00);
        chk("ack1_sel", {6'd0, bus.vector_byte_select}, 8'h01);
        chk("ack1_int", {7'd0, bus.interrupt_to_cpu}, 8'h00);
        chk("ack1_vec", bus.acknowledge_interrupt, 8'h08);
        step();
        inta();
        chk("ack2_sel", {6'd0, bus.vector_byte_select}, 8'h00);
        chk("ack2_eoa", {7'd0, bus.end_of_acknowledge_sequence}, 8'h01);
        step();
        chk("ack2_eoa_drop", {7'd0, bus.end_of_acknowledge_sequence}, 8'h00);
        chk("nest_hlis", bus.highest_level_in_service, 8'h08);

        // nesting against in-service IR3
        bus.interrupt_request = 8'h28;
        step();
        chk("ir5_irr", bus.interrupt_request_register, 8'h20);
        step();
        chk("ir5_int", {7'd0, bus.interrupt_to_cpu}, 8'h00);
        bus.interrupt_request = 8'h2A;
        step();
        step();
        chk("ir1_int", {7'd0, bus.interrupt_to_cpu}, 8'h01);
        bus.interrupt_request = 8'h00;
        eoi(8'h08);
        chk("eoi3_isr", bus.in_service_register, 8'h00);
        chk("eoi3_hlis", bus.highest_level_in_service, 8'h00);
        step();

        // simultaneous IR2/IR5 under two rotations
        bus.interrupt_request = 8'h24;
        step();
        step();
        inta();
        chk("rot7_vec", bus.acknowledge_interrupt, 8'h04);
        chk("rot7_isr", bus.in_service_register, 8'h04);
        chk("rot7_irr", bus.interrupt_request_register, 8'h20);
        step();
        inta();
        step();
        eoi(8'h04);
        bus.interrupt_request = 8'h00;
        step();
        step();
        bus.interrupt_request = 8'h24;
        bus.priority_rotate = 3'd3;
        step();
        step();
        inta();
        chk("rot3_vec", bus.acknowledge_interrupt, 8'h20);
        chk("rot3_hlis", bus.highest_level_in_service, 8'h20);
        step();
        inta();
        step();
        bus.interrupt_request = 8'h00;
        eoi(8'hFF);
        bus.priority_rotate = 3'd7;
        step();

        // level mode re-asserts on a held line
        bus.level_or_edge_triggered = 1'b1;
        bus.interrupt_request = 8'h10;
        step();
        chk("lvl_irr", bus.interrupt_request_register, 8'h10);
        step();
        inta();
        chk("lvl_ack_irr", bus.interrupt_request_register, 8'h00);
        step();
        chk("lvl_irr_back", bus.interrupt_request_register, 8'h10);
        inta();
        step();
        eoi(8'h10);
        step();
        chk("lvl_reint", {7'd0, bus.interrupt_to_cpu}, 8'h01);

        // same held line in edge mode needs a fresh rise
        bus.level_or_edge_triggered = 1'b0;
        inta();
        chk("edg_isr", bus.in_service_register, 8'h10);
        chk("edg_irr", bus.interrupt_request_register, 8'h00);
        step();
        inta();
        step();
        eoi(8'h10);
        step();
        step();
        chk("edg_noint", {7'd0, bus.interrupt_to_cpu}, 8'h00);
        bus.interrupt_request = 8'h00;
        step();
        bus.interrupt_request = 8'h10;
        step();
        chk("edg_rise_irr", bus.interrupt_request_register, 8'h10);
        step();
        chk("edg_rise_int", {7'd0, bus.interrupt_to_cpu}, 8'h01);
        inta();
        step();
        inta();
        step();
        bus.interrupt_request = 8'h00;
        eoi(8'hFF);

        // MCS-80 three-pulse sequence
        bus.u8086_or_mcs80_config = 1'b0;
        bus.interrupt_request = 8'h01;
        step();
        step();
        inta();
        chk("mcs_sel1", {6'd0, bus.vector_byte_select}, 8'h01);
        step();
        inta();
        chk("mcs_sel2", {6'd0, bus.vector_byte_select}, 8'h02);
        chk("mcs_eoa2", {7'd0, bus.end_of_acknowledge_sequence}, 8'h00);
        step();
        inta();
        chk("mcs_sel0", {6'd0, bus.vector_byte_select}, 8'h00);
        chk("mcs_eoa3", {7'd0, bus.end_of_acknowledge_sequence}, 8'h01);
        step();
        bus.interrupt_request = 8'h00;
        eoi(8'hFF);

        // clear_all aborts mid-sequence without an end pulse
        bus.interrupt_request = 8'h02;
        step();
        step();
        inta();
        step();
        inta();
        chk("clr_pre_sel", {6'd0, bus.vector_byte_select}, 8'h02);
        bus.clear_all = 1'b1;
        step();
        bus.clear_all = 1'b0;
        chk("clr_sel", {6'd0, bus.vector_byte_select}, 8'h00);
        chk("clr_isr", bus.in_service_register, 8'h00);
        chk("clr_vec", bus.acknowledge_interrupt, 8'h00);
        chk("clr_eoa", {7'd0, bus.end_of_acknowledge_sequence}, 8'h00);
        step();
        chk("clr_eoa_next", {7'd0, bus.end_of_acknowledge_sequence}, 8'h00);
        chk("clr_irr", bus.interrupt_request_register, 8'h00);
        bus.interrupt_request = 8'h00;
        bus.u8086_or_mcs80_config = 1'b1;
        step();

        // spurious acknowledge after a withdrawn IR6
        bus.interrupt_request = 8'h40;
        step();
        step();
        chk("ir6_int", {7'd0, bus.interrupt_to_cpu}, 8'h01);
        bus.interrupt_request = 8'h00;
        step();
        inta();
        chk("spur_vec", bus.acknowledge_interrupt, 8'h80);
        chk("spur_isr", bus.in_service_register, 8'h00);
        step();
        inta();
        step();

        // async reset in the middle of a sequence
        bus.interrupt_request = 8'h08;
        step();
        step();
        inta();
        chk("pre_rst_isr", bus.in_service_register, 8'h08);
        reset = 1'b1;
        #1;
        all_zero("mid_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
